// File: rtl/usbdev_pkg.sv
// rtl/usbdev_pkg.sv - shared types and constants for the usbdev AON wake logic
package usbdev_pkg;

  // Per-port AON wake FSM states.
  typedef enum logic [1:0] {
    AwkIdle   = 2'd0,
    AwkActive = 2'd1,
    AwkWake   = 2'd2
  } awk_state_e;

  // Bit positions inside the wake source mask.
  localparam int unsigned AwkEvNotIdle   = 0;
  localparam int unsigned AwkEvBusReset  = 1;
  localparam int unsigned AwkEvSenseLost = 2;

endpackage

// File: rtl/prim_filter.sv
// rtl/prim_filter.sv - debounce filter: output follows input once stable for Cycles samples
module prim_filter #(
  parameter bit          AsyncOn = 1'b0,
  parameter int unsigned Cycles  = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic filter_i,
  output logic filter_o
);

  logic              synced;
  logic [Cycles-1:0] hist_q, hist_d;
  logic              stored_q, stored_d;

  if (AsyncOn) begin : gen_async
    prim_flop_2sync #(.Width(1)) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (filter_i),
      .q_o    (synced)
    );
  end else begin : gen_sync
    assign synced = filter_i;
  end

  // The window holds the current sample plus the previous Cycles-1; a unanimous window updates the output.
  always_comb begin
    hist_d   = (hist_q << 1) | Cycles'(synced);
    stored_d = stored_q;
    if (&hist_d) begin
      stored_d = 1'b1;
    end else if (~|hist_d) begin
      stored_d = 1'b0;
    end
  end

  // Sample history and filtered value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q   <= '0;
      stored_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      stored_q <= stored_d;
    end
  end

  assign filter_o = stored_q;

endmodule

// File: rtl/prim_flop_2sync.sv
// rtl/prim_flop_2sync.sv - two-flop synchroniser for signals from another clock domain
module prim_flop_2sync #(
  parameter int unsigned       Width      = 1,
  parameter logic [Width-1:0]  ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage1_q, stage2_q;

  // Two back-to-back flops give the first stage a full cycle to resolve metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage1_q <= ResetValue;
      stage2_q <= ResetValue;
    end else begin
      stage1_q <= d_i;
      stage2_q <= stage1_q;
    end
  end

  assign q_o = stage2_q;

endmodule

// File: rtl/usbdev_aon_wake_port.sv
// rtl/usbdev_aon_wake_port.sv - suspend/wake monitor for a single USB port
module usbdev_aon_wake_port
  import usbdev_pkg::*;
#(
  parameter int unsigned FilterCycles = 4,
  parameter int unsigned ResetCycles  = 3,
  parameter int unsigned SenseCycles  = 3,
  parameter int unsigned TimeoutW     = 16
) (
  input  logic                clk_aon_i,
  input  logic                rst_aon_ni,
  input  logic                usb_dp_i,
  input  logic                usb_dn_i,
  input  logic                usb_sense_i,
  input  logic                usbdev_dppullup_en_i,
  input  logic                usbdev_dnpullup_en_i,
  input  logic                suspend_req_aon_i,
  input  logic                wake_ack_aon_i,
  input  logic [2:0]          event_en_aon_i,
  input  logic [TimeoutW-1:0] timeout_aon_i,
  output logic                usb_dppullup_en_o,
  output logic                usb_dnpullup_en_o,
  output logic                wake_aon_o,
  output logic                active_aon_o,
  output logic                bus_not_idle_aon_o,
  output logic                bus_reset_aon_o,
  output logic                sense_lost_aon_o,
  output logic                timeout_aon_o
);

  awk_state_e          state_q, state_d;
  logic [TimeoutW-1:0] cnt_q, cnt_d;
  logic [1:0]          pu_sync, pu_q;      // {dn, dp}
  logic [3:0]          flags_q, flags_d;   // {timeout, sense_lost, bus_reset, not_idle}
  logic                in_idle, timeout_hit, wake_event;
  logic                not_idle_async, se0_async, sense_lost_async;
  logic                flt_not_idle, flt_se0, flt_sense_lost;

  // While suspended the pads keep the pull-ups latched before suspend; otherwise the IP drives them.
  assign in_idle           = (state_q == AwkIdle);
  assign usb_dppullup_en_o = in_idle ? usbdev_dppullup_en_i : pu_q[0];
  assign usb_dnpullup_en_o = in_idle ? usbdev_dnpullup_en_i : pu_q[1];

  assign not_idle_async   = (usb_dp_i != usb_dppullup_en_o) | (usb_dn_i != usb_dnpullup_en_o);
  assign se0_async        = ~usb_dp_i & ~usb_dn_i;
  assign sense_lost_async = ~usb_sense_i;

  prim_filter #(.AsyncOn(1'b1), .Cycles(FilterCycles)) u_filter_not_idle (
    .clk_i(clk_aon_i), .rst_ni(rst_aon_ni), .filter_i(not_idle_async), .filter_o(flt_not_idle)
  );
  prim_filter #(.AsyncOn(1'b1), .Cycles(ResetCycles)) u_filter_se0 (
    .clk_i(clk_aon_i), .rst_ni(rst_aon_ni), .filter_i(se0_async), .filter_o(flt_se0)
  );
  prim_filter #(.AsyncOn(1'b1), .Cycles(SenseCycles)) u_filter_sense (
    .clk_i(clk_aon_i), .rst_ni(rst_aon_ni), .filter_i(sense_lost_async), .filter_o(flt_sense_lost)
  );

  prim_flop_2sync #(.Width(2)) u_pullup_sync (
    .clk_i  (clk_aon_i),
    .rst_ni (rst_aon_ni),
    .d_i    ({usbdev_dnpullup_en_i, usbdev_dppullup_en_i}),
    .q_o    (pu_sync)
  );

  assign timeout_hit = (timeout_aon_i != '0) && (cnt_q == timeout_aon_i);
  assign wake_event  = (flt_not_idle   & event_en_aon_i[AwkEvNotIdle])
                     | (flt_se0        & event_en_aon_i[AwkEvBusReset])
                     | (flt_sense_lost & event_en_aon_i[AwkEvSenseLost])
                     | timeout_hit;

  // Next state: an ack always wins over a same-cycle suspend request or wake event.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      AwkIdle:   if (suspend_req_aon_i && !wake_ack_aon_i) state_d = AwkActive;
      AwkActive: begin
        if (wake_ack_aon_i)  state_d = AwkIdle;
        else if (wake_event) state_d = AwkWake;
      end
      AwkWake:   if (wake_ack_aon_i) state_d = AwkIdle;
      default:   state_d = AwkIdle;
    endcase
  end

  // Timeout counter: zero in IDLE (so it starts from 0 on entry), counts ACTIVE cycles, saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (in_idle) begin
      cnt_d = '0;
    end else if ((state_q == AwkActive) && (cnt_q != '1)) begin
      cnt_d = cnt_q + TimeoutW'(1);
    end
  end

  // Sticky flags record raw events while suspended and are wiped whenever the port goes IDLE.
  always_comb begin
    flags_d = flags_q;
    if (state_d == AwkIdle) begin
      flags_d = '0;
    end else if (!in_idle) begin
      flags_d = flags_q | {timeout_hit, flt_sense_lost, flt_se0, flt_not_idle};
    end
  end

  // State, counter, flags and the pull-up latch (transparent only in IDLE).
  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) begin
      state_q <= AwkIdle;
      cnt_q   <= '0;
      flags_q <= '0;
      pu_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      if (in_idle) pu_q <= pu_sync;
    end
  end

  assign wake_aon_o         = (state_q == AwkWake);
  assign active_aon_o       = !in_idle;
  assign bus_not_idle_aon_o = flags_q[0];
  assign bus_reset_aon_o    = flags_q[1];
  assign sense_lost_aon_o   = flags_q[2];
  assign timeout_aon_o      = flags_q[3];

endmodule

// File: rtl/usbdev_aon_wake_mp.sv
// rtl/usbdev_aon_wake_mp.sv - multi-port AON USB suspend/wake monitor
module usbdev_aon_wake_mp
  import usbdev_pkg::*;
#(
  parameter int unsigned NumPorts     = 2,
  parameter int unsigned FilterCycles = 4,
  parameter int unsigned ResetCycles  = 3,
  parameter int unsigned SenseCycles  = 3,
  parameter int unsigned TimeoutW     = 16
) (
  input  logic                clk_aon_i,
  input  logic                rst_aon_ni,
  input  logic [NumPorts-1:0] usb_dp_i,
  input  logic [NumPorts-1:0] usb_dn_i,
  input  logic [NumPorts-1:0] usb_sense_i,
  input  logic [NumPorts-1:0] usbdev_dppullup_en_i,
  input  logic [NumPorts-1:0] usbdev_dnpullup_en_i,
  input  logic [NumPorts-1:0] suspend_req_aon_i,
  input  logic [NumPorts-1:0] wake_ack_aon_i,
  input  logic [2:0]          event_en_aon_i,
  input  logic [TimeoutW-1:0] timeout_aon_i,
  output logic [NumPorts-1:0] usb_dppullup_en_o,
  output logic [NumPorts-1:0] usb_dnpullup_en_o,
  output logic                wake_req_aon_o,
  output logic [NumPorts-1:0] wake_port_aon_o,
  output logic [NumPorts-1:0] wake_detect_active_aon_o,
  output logic [NumPorts-1:0] bus_not_idle_aon_o,
  output logic [NumPorts-1:0] bus_reset_aon_o,
  output logic [NumPorts-1:0] sense_lost_aon_o,
  output logic [NumPorts-1:0] timeout_aon_o
);

  for (genvar i = 0; i < NumPorts; i++) begin : gen_port
    usbdev_aon_wake_port #(
      .FilterCycles (FilterCycles),
      .ResetCycles  (ResetCycles),
      .SenseCycles  (SenseCycles),
      .TimeoutW     (TimeoutW)
    ) u_port (
      .clk_aon_i            (clk_aon_i),
      .rst_aon_ni           (rst_aon_ni),
      .usb_dp_i             (usb_dp_i[i]),
      .usb_dn_i             (usb_dn_i[i]),
      .usb_sense_i          (usb_sense_i[i]),
      .usbdev_dppullup_en_i (usbdev_dppullup_en_i[i]),
      .usbdev_dnpullup_en_i (usbdev_dnpullup_en_i[i]),
      .suspend_req_aon_i    (suspend_req_aon_i[i]),
      .wake_ack_aon_i       (wake_ack_aon_i[i]),
      .event_en_aon_i       (event_en_aon_i),
      .timeout_aon_i        (timeout_aon_i),
      .usb_dppullup_en_o    (usb_dppullup_en_o[i]),
      .usb_dnpullup_en_o    (usb_dnpullup_en_o[i]),
      .wake_aon_o           (wake_port_aon_o[i]),
      .active_aon_o         (wake_detect_active_aon_o[i]),
      .bus_not_idle_aon_o   (bus_not_idle_aon_o[i]),
      .bus_reset_aon_o      (bus_reset_aon_o[i]),
      .sense_lost_aon_o     (sense_lost_aon_o[i]),
      .timeout_aon_o        (timeout_aon_o[i])
    );
  end

  // Any port in WAKE requests a chip wake-up.
  assign wake_req_aon_o = |wake_port_aon_o;

endmodule

// File: tb/tb_usbdev_aon_wake_mp.sv
// tb/tb_usbdev_aon_wake_mp.sv - self-checking bench for usbdev_aon_wake_mp
module tb_usbdev_aon_wake_mp;

  localparam int NP    = 2;
  localparam int FILT  = 4;
  localparam int RSTC  = 3;
  localparam int SENC  = 3;
  localparam int NEVER = 100000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP-1:0] dp = '1, dn = '0, sense = '1, pu_dp = '1, pu_dn = '0, susp = '0, ack = '0;
  logic [2:0]    en = 3'b000;
  logic [15:0]   tmo = 16'd0;
  logic [NP-1:0] usb_dppu, usb_dnpu, wake_port, active, f_ni, f_rst, f_sl, f_to;
  logic          wake_req;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  usbdev_aon_wake_mp #(
    .NumPorts(NP), .FilterCycles(FILT), .ResetCycles(RSTC), .SenseCycles(SENC), .TimeoutW(16)
  ) dut (
    .clk_aon_i                (clk),
    .rst_aon_ni               (rst_n),
    .usb_dp_i                 (dp),
    .usb_dn_i                 (dn),
    .usb_sense_i              (sense),
    .usbdev_dppullup_en_i     (pu_dp),
    .usbdev_dnpullup_en_i     (pu_dn),
    .suspend_req_aon_i        (susp),
    .wake_ack_aon_i           (ack),
    .event_en_aon_i           (en),
    .timeout_aon_i            (tmo),
    .usb_dppullup_en_o        (usb_dppu),
    .usb_dnpullup_en_o        (usb_dnpu),
    .wake_req_aon_o           (wake_req),
    .wake_port_aon_o          (wake_port),
    .wake_detect_active_aon_o (active),
    .bus_not_idle_aon_o       (f_ni),
    .bus_reset_aon_o          (f_rst),
    .sense_lost_aon_o         (f_sl),
    .timeout_aon_o            (f_to)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({wake_req, wake_port, active, f_ni, f_rst, f_sl, f_to} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got %b want 0", {wake_req, wake_port, active, f_ni, f_rst, f_sl, f_to});
    end
    tests_run++;
    if ({usb_dppu, usb_dnpu} !== {pu_dp, pu_dn}) begin
      tests_failed++;
      $display("FAIL reset_pullups got %b want %b", {usb_dppu, usb_dnpu}, {pu_dp, pu_dn});
    end
    rst_n = 1'b1;
    repeat (8) tick();
    tests_run++;
    if (active !== '0) begin
      tests_failed++;
      $display("FAIL reset_release_active got %b want 00", active);
    end
  endtask

  // Reference model: each raw event whose line condition holds for at least its filter length
  // reaches the flags d+Cycles+3 edges after suspend; wake is the earliest enabled event, or the
  // timeout at T+1 edges provided the ACTIVE-cycle count reaches T before any other wake.
  task automatic run_event_case(input string name, input int p, input bit pdp, input bit pdn,
                                input bit psense, input int d, input int h, input bit [2:0] ena,
                                input int t);
    int cyc[3];
    bit cond[3];
    int ev_edge[3];
    int w_ev, t_edge, w, o;
    bit exp_wake;
    bit [3:0] exp_flags, got_flags;
    o = 1 - p;
    cyc[0] = FILT; cyc[1] = RSTC; cyc[2] = SENC;
    cond[0] = (pdp != 1'b1) || (pdn != 1'b0);
    cond[1] = !pdp && !pdn;
    cond[2] = !psense;
    w_ev = NEVER;
    for (int e = 0; e < 3; e++) begin
      ev_edge[e] = (cond[e] && h >= cyc[e]) ? d + cyc[e] + 3 : NEVER;
      if (ena[e] && ev_edge[e] < w_ev) w_ev = ev_edge[e];
    end
    t_edge = (t != 0 && t <= w_ev) ? t + 1 : NEVER;
    w = (t_edge < w_ev) ? t_edge : w_ev;
    en = ena;
    tmo = 16'(t);
    susp[p] = 1'b1;
    tick();
    susp[p] = 1'b0;
    tests_run++;
    if (active[p] !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s active_after_suspend got %b want 1", name, active[p]);
    end
    for (int k = 1; k <= 20; k++) begin
      if (k - 1 == d) begin dp[p] = pdp; dn[p] = pdn; sense[p] = psense; end
      if (k - 1 == d + h) begin dp[p] = 1'b1; dn[p] = 1'b0; sense[p] = 1'b1; end
      tick();
      exp_wake  = (k >= w);
      exp_flags = {k >= t_edge, k >= ev_edge[2], k >= ev_edge[1], k >= ev_edge[0]};
      got_flags = {f_to[p], f_sl[p], f_rst[p], f_ni[p]};
      tests_run++;
      if ({wake_port[p], wake_req} !== {exp_wake, exp_wake}) begin
        tests_failed++;
        $display("FAIL %s wake edge %0d got port=%b req=%b want %b", name, k, wake_port[p], wake_req, exp_wake);
      end
      tests_run++;
      if (got_flags !== exp_flags) begin
        tests_failed++;
        $display("FAIL %s flags edge %0d got %b want %b", name, k, got_flags, exp_flags);
      end
      tests_run++;
      if ({wake_port[o], active[o]} !== 2'b00) begin
        tests_failed++;
        $display("FAIL %s other_port edge %0d got %b want 00", name, k, {wake_port[o], active[o]});
      end
    end
    ack[p] = 1'b1;
    tick();
    ack[p] = 1'b0;
    tests_run++;
    if ({active[p], wake_port[p], f_to[p], f_sl[p], f_rst[p], f_ni[p]} !== '0) begin
      tests_failed++;
      $display("FAIL %s after_ack got %b want 0", name, {active[p], wake_port[p], f_to[p], f_sl[p], f_rst[p], f_ni[p]});
    end
    repeat (12) tick();
  endtask

  task automatic test_not_idle();
    run_event_case("not_idle", 0, 1'b0, 1'b1, 1'b1, 1, 10, 3'b001, 0);
  endtask

  task automatic test_bus_reset();
    run_event_case("bus_reset", 0, 1'b0, 1'b0, 1'b1, 1, 10, 3'b001, 0);
    run_event_case("glitch", 1, 1'b0, 1'b1, 1'b1, 2, 2, 3'b010, 0);
  endtask

  task automatic test_timeout();
    run_event_case("timeout5", 0, 1'b1, 1'b0, 1'b1, 0, 1, 3'b000, 5);
  endtask

  task automatic test_timeout_disabled();
    int wakes = 0;
    en = 3'b000;
    tmo = 16'd0;
    susp[0] = 1'b1;
    tick();
    susp[0] = 1'b0;
    for (int k = 0; k < 70000; k++) begin
      tick();
      if (wake_req !== 1'b0) wakes++;
    end
    tests_run++;
    if (wakes != 0 || active[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_disabled wake_cycles=%0d active=%b want 0 and 1", wakes, active[0]);
    end
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_ack_priority();
    susp[0] = 1'b1;
    ack[0] = 1'b1;
    tick();
    susp[0] = 1'b0;
    ack[0] = 1'b0;
    tests_run++;
    if (active[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL susp_ack_idle got %b want 0", active[0]);
    end
    tick();
    tests_run++;
    if (active[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL susp_ack_idle_hold got %b want 0", active[0]);
    end
    en = 3'b001;
    tmo = 16'd0;
    susp[1] = 1'b1;
    tick();
    susp[1] = 1'b0;
    dp[1] = 1'b0;
    dn[1] = 1'b1;
    repeat (FILT + 2) tick();
    tests_run++;
    if (wake_port[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL event_ack_pre got %b want 0", wake_port[1]);
    end
    ack[1] = 1'b1;
    tick();
    ack[1] = 1'b0;
    tests_run++;
    if ({active[1], wake_port[1], f_ni[1], f_rst[1], f_sl[1], f_to[1]} !== '0) begin
      tests_failed++;
      $display("FAIL event_ack_same got %b want 0", {active[1], wake_port[1], f_ni[1], f_rst[1], f_sl[1], f_to[1]});
    end
    tick();
    tests_run++;
    if ({active[1], f_ni[1]} !== 2'b00) begin
      tests_failed++;
      $display("FAIL event_ack_hold got %b want 00", {active[1], f_ni[1]});
    end
    dp[1] = 1'b1;
    dn[1] = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_pullup();
    en = 3'b000;
    tmo = 16'd0;
    susp[0] = 1'b1;
    tick();
    susp[0] = 1'b0;
    pu_dp[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (usb_dppu[0] !== 1'b1) begin
        tests_failed++;
        $display("FAIL pullup_hold cycle %0d got %b want 1", k, usb_dppu[0]);
      end
    end
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    tests_run++;
    if (usb_dppu[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL pullup_after_ack got %b want 0", usb_dppu[0]);
    end
    pu_dp[0] = 1'b1;
    #1;
    tests_run++;
    if (usb_dppu[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL pullup_comb_idle got %b want 1", usb_dppu[0]);
    end
    repeat (12) tick();
  endtask

  task automatic test_reset_mid_wake();
    en = 3'b000;
    tmo = 16'd3;
    susp[0] = 1'b1;
    tick();
    susp[0] = 1'b0;
    repeat (4) tick();
    pu_dp[0] = 1'b0;
    tests_run++;
    if (wake_port[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_in_wake got %b want 1", wake_port[0]);
    end
    tick();
    tests_run++;
    if (usb_dppu[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_latched got %b want 1", usb_dppu[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({wake_req, wake_port, active, f_ni, f_rst, f_sl, f_to} !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs got %b want 0", {wake_req, wake_port, active, f_ni, f_rst, f_sl, f_to});
    end
    tests_run++;
    if ({usb_dppu, usb_dnpu} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL rst_mid_pullups got %b want 1000", {usb_dppu, usb_dnpu});
    end
    pu_dp[0] = 1'b1;
    tick();
    rst_n = 1'b1;
    tmo = 16'd0;
    repeat (12) tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      run_event_case("random", int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                     int'($urandom_range(0, 4)), int'($urandom_range(1, 8)),
                     3'($urandom_range(0, 7)),
                     ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 15)) : 0);
    end
  endtask

  initial begin
    test_reset();
    test_not_idle();
    test_bus_reset();
    test_timeout();
    test_ack_priority();
    test_pullup();
    test_reset_mid_wake();
    test_random();
    test_timeout_disabled();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
